tmu_tag_mgr: RTL and testbench
==============================

Name: tmu_tag_mgr

Overview:
- Parametrised next-generation tag management unit for the EGR partition.
- Accepts tags from the tag ring, buffers them in NUM_CH independent per-channel FIFOs and issues them to PFS over one valid/ready output.
- Issue order is round-robin across channels.
- Adds per-channel enable and flush, occupancy reporting and a saturating drop counter.

Parameters:
NUM_CH, 8, number of tag channels (destination queues); power of two not required
DEPTH, 16, entries per channel FIFO; power of two
TAG_W, 64, tag payload width in bits
CH_W, $clog2(NUM_CH) (min 1), channel index width
CNT_W, $clog2(DEPTH+1), occupancy counter width
DROP_W, 16, drop counter width

Ports:
clk  in  1  core clock
rst  in  1  asynchronous, active-high reset
tag_in_valid  in  1  tag present this cycle; no backpressure
tag_in_chan  in  CH_W  destination channel of incoming tag
tag_in_data  in  TAG_W  tag payload
tag_in_drop  out  1  registered pulse; the tag presented last cycle was dropped
chan_enable  in  NUM_CH  per-channel arbitration enable
chan_flush  in  NUM_CH  per-channel synchronous flush, level-sensitive
tag_out_valid  out  1  output tag valid
tag_out_ready  in  1  PFS accepts output tag
tag_out_chan  out  CH_W  channel of output tag
tag_out_data  out  TAG_W  output tag payload
chan_occ  out  NUM_CH*CNT_W  per-channel occupancy; channel i at bits [i*CNT_W +: CNT_W]
drop_cnt  out  DROP_W  saturating count of dropped tags
drop_clr  in  1  synchronous clear of drop_cnt

Behaviour:
- Clock and reset: one clock (clk); reset (rst) is asynchronous and active-high.
- Reset values: tag_out_valid=0, tag_out_chan=0, tag_out_data=0, tag_in_drop=0, all chan_occ=0, drop_cnt=0, all read/write pointers=0, RR pointer=0.
- FIFO storage contents are don't-care after reset.
- Push:
  - When tag_in_valid=1, the tag is written to FIFO[tag_in_chan].
  - Full is evaluated on start-of-cycle occupancy. A push to a full FIFO is dropped even if the same channel pops in that cycle.
  - Drop cases: tag_in_chan >= NUM_CH; target FIFO full; chan_flush[tag_in_chan]=1 in that cycle.
  - Any drop asserts tag_in_drop on the next cycle and increments drop_cnt.
- drop_cnt:
  - Saturates at 2^DROP_W-1.
  - drop_clr has priority; a drop in the same cycle as drop_clr leaves drop_cnt=0.
- Output stage:
  - Single register (tag_out_*). It loads when (!tag_out_valid || tag_out_ready) and at least one channel is eligible.
  - Eligible = occupancy != 0, chan_enable=1, chan_flush=0.
  - Payload and channel are stable while tag_out_valid && !tag_out_ready.
  - tag_out_valid deasserts only after a handshake with no eligible channel.
  - Throughput is 1 tag per cycle.
- Latency: a tag pushed in cycle t into an empty system with ready=1 appears on tag_out in cycle t+1. No same-cycle bypass.
- Arbitration:
  - Round-robin starting at the RR pointer. After a grant to channel g, the pointer becomes (g+1) mod NUM_CH.
  - With no grant, the pointer is unchanged.
  - Disabled channels keep accepting pushes but are skipped by the arbiter.
- Occupancy: chan_occ[i] = pushes minus pops minus flushes; registered. Simultaneous push and pop on a non-full channel leaves it unchanged.
- Flush:
  - chan_flush[i]=1 sets occ[i]=0 and rd_ptr=wr_ptr next cycle.
  - A tag already in the output register is unaffected and still handed off.
  - A push or pop to i in a flush cycle is suppressed (push counted as drop).
- Wrap-around: pointers are log2(DEPTH) bits and wrap naturally. Full is occ==DEPTH; empty is occ==0.
- Reset asserted mid-transfer discards all buffered and output tags immediately (async). No handshake completes in a reset cycle.

Test Plan:
- Single tag: reset, push chan=3 data=0xA5 at cycle 0, ready=1 -> tag_out_valid=1, chan=3, data=0xA5 at cycle 1; chan_occ[3]: 1 after cycle 0, 0 after cycle 1.
- Fill and drop: ready=0, push 17 tags to chan 0 (DEPTH=16) -> chan_occ[0]=16; 17th gives tag_in_drop=1 next cycle, drop_cnt=1. With ready=1, the 16 accepted tags drain in push order.
- Round-robin: preload 2 tags each in chans 0, 2, 5; ready=1 -> output chan order 0,2,5,0,2,5 on consecutive cycles.
- Backpressure: hold ready=0 for 5 cycles with tag_out_valid=1 -> tag_out_data/chan unchanged; occupancies grow only by pushes.
- Enable and flush:
  - chan_enable[2]=0 with chan 2 holding 4 tags -> chan 2 never issued.
  - Pulse chan_flush[2] -> chan_occ[2]=0. A push to chan 2 in the flush cycle is dropped and drop_cnt increments.
- Invalid channel and saturation: DROP_W=4, push to chan=NUM_CH 20 times -> drop_cnt=15 saturates.
  - drop_clr together with a drop -> drop_cnt=0.
  - Async rst mid-stream -> all outputs 0 without a clock edge.

Source files
------------

// File: rtl/tmu_tag_mgr.sv
// rtl/tmu_tag_mgr.sv - per-channel tag FIFOs with round-robin issue to a single output register
//
// Ports:
//   clk, rst                    core clock, asynchronous active-high reset
//   tag_in_valid/chan/data      tag ring input, no backpressure
//   tag_in_drop                 registered pulse: the tag presented last cycle was dropped
//   chan_enable, chan_flush     per-channel arbitration enable and level-sensitive flush
//   tag_out_valid/ready/chan/data  issue port towards PFS
//   chan_occ                    per-channel occupancy, channel i at [i*CNT_W +: CNT_W]
//   drop_cnt, drop_clr          saturating drop counter and its synchronous clear
module tmu_tag_mgr #(
   parameter int NUM_CH = 8,
   parameter int DEPTH  = 16,
   parameter int TAG_W  = 64,
   parameter int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
   parameter int CNT_W  = $clog2(DEPTH + 1),
   parameter int DROP_W = 16
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    tag_in_valid,
   input  logic [CH_W-1:0]         tag_in_chan,
   input  logic [TAG_W-1:0]        tag_in_data,
   output logic                    tag_in_drop,
   input  logic [NUM_CH-1:0]       chan_enable,
   input  logic [NUM_CH-1:0]       chan_flush,
   output logic                    tag_out_valid,
   input  logic                    tag_out_ready,
   output logic [CH_W-1:0]         tag_out_chan,
   output logic [TAG_W-1:0]        tag_out_data,
   output logic [NUM_CH*CNT_W-1:0] chan_occ,
   output logic [DROP_W-1:0]       drop_cnt,
   input  logic                    drop_clr
);

   // DEPTH is a power of two, so the pointers wrap by plain overflow.
   localparam int                PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [CNT_W-1:0]  OCC_FULL = CNT_W'(DEPTH);
   localparam logic [DROP_W-1:0] DROP_MAX = '1;

   logic [TAG_W-1:0]  mem    [NUM_CH][DEPTH];
   logic [PTR_W-1:0]  wr_ptr [NUM_CH];
   logic [PTR_W-1:0]  rd_ptr [NUM_CH];
   logic [CNT_W-1:0]  occ    [NUM_CH];

   logic [NUM_CH-1:0] push_ok;
   logic [NUM_CH-1:0] eligible;
   logic [NUM_CH-1:0] pop;
   logic              in_drop;
   logic              load;
   logic              grant_vld;
   logic [CH_W-1:0]   grant;
   logic [CH_W-1:0]   rr_ptr;
   logic [CH_W-1:0]   rr_next;
   logic [TAG_W-1:0]  grant_data;

   // Push acceptance uses start-of-cycle occupancy, so a full channel drops
   // the incoming tag even when it is also being popped this cycle. A channel
   // index outside 0..NUM_CH-1 matches no decoder term and therefore drops.
   always_comb begin
      push_ok = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         push_ok[i] = tag_in_valid && (tag_in_chan == CH_W'(i)) &&
                      (occ[i] != OCC_FULL) && !chan_flush[i];
      end
      in_drop = tag_in_valid && (push_ok == '0);
   end

   // Round-robin: first search channels at or above the RR pointer, then
   // wrap around to the lowest eligible channel.
   always_comb begin
      eligible  = '0;
      grant     = '0;
      grant_vld = 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
         eligible[i] = (occ[i] != '0) && chan_enable[i] && !chan_flush[i];
      end
      for (int i = 0; i < NUM_CH; i++) begin
         if (!grant_vld && eligible[i] && (CH_W'(i) >= rr_ptr)) begin
            grant_vld = 1'b1;
            grant     = CH_W'(i);
         end
      end
      for (int i = 0; i < NUM_CH; i++) begin
         if (!grant_vld && eligible[i]) begin
            grant_vld = 1'b1;
            grant     = CH_W'(i);
         end
      end
   end

   always_comb begin
      load       = (!tag_out_valid || tag_out_ready) && grant_vld;
      pop        = '0;
      grant_data = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         pop[i] = load && (grant == CH_W'(i));
         if (grant == CH_W'(i)) begin
            grant_data = mem[i][rd_ptr[i]];
         end
      end
      rr_next = (grant == CH_W'(NUM_CH - 1)) ? '0 : grant + CH_W'(1);
   end

   // Storage has no reset; contents are only observed through valid pointers.
   always_ff @(posedge clk) begin
      for (int i = 0; i < NUM_CH; i++) begin
         if (push_ok[i]) begin
            mem[i][wr_ptr[i]] <= tag_in_data;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NUM_CH; i++) begin
            wr_ptr[i] <= '0;
            rd_ptr[i] <= '0;
            occ[i]    <= '0;
         end
         tag_out_valid <= 1'b0;
         tag_out_chan  <= '0;
         tag_out_data  <= '0;
         rr_ptr        <= '0;
         tag_in_drop   <= 1'b0;
         drop_cnt      <= '0;
      end else begin
         for (int i = 0; i < NUM_CH; i++) begin
            // Flush empties the channel by catching the read side up to the
            // write side; push_ok and pop are already masked by the flush.
            if (chan_flush[i]) begin
               occ[i]    <= '0;
               rd_ptr[i] <= wr_ptr[i];
            end else begin
               if (push_ok[i]) begin
                  wr_ptr[i] <= wr_ptr[i] + PTR_W'(1);
               end
               if (pop[i]) begin
                  rd_ptr[i] <= rd_ptr[i] + PTR_W'(1);
               end
               occ[i] <= occ[i] + CNT_W'(push_ok[i]) - CNT_W'(pop[i]);
            end
         end

         if (load) begin
            tag_out_valid <= 1'b1;
            tag_out_chan  <= grant;
            tag_out_data  <= grant_data;
            rr_ptr        <= rr_next;
         end else if (tag_out_ready) begin
            tag_out_valid <= 1'b0;
         end

         tag_in_drop <= in_drop;
         if (drop_clr) begin
            drop_cnt <= '0;
         end else if (in_drop && (drop_cnt != DROP_MAX)) begin
            drop_cnt <= drop_cnt + DROP_W'(1);
         end
      end
   end

   always_comb begin
      chan_occ = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         chan_occ[i*CNT_W +: CNT_W] = occ[i];
      end
   end

endmodule

// File: tb/tb_tmu_tag_mgr.sv
// tb/tb_tmu_tag_mgr.sv - self-checking bench for tmu_tag_mgr with a queue-based reference model
module tb_tmu_tag_mgr;

   localparam int NUM_CH = 6;
   localparam int DEPTH  = 16;
   localparam int TAG_W  = 32;
   localparam int DROP_W = 4;
   localparam int CH_W   = $clog2(NUM_CH);
   localparam int CNT_W  = $clog2(DEPTH + 1);
   localparam int DMAX   = (1 << DROP_W) - 1;

   logic                    clk = 1'b0;
   logic                    rst = 1'b0;
   logic                    tag_in_valid;
   logic [CH_W-1:0]         tag_in_chan;
   logic [TAG_W-1:0]        tag_in_data;
   logic                    tag_in_drop;
   logic [NUM_CH-1:0]       chan_enable;
   logic [NUM_CH-1:0]       chan_flush;
   logic                    tag_out_valid;
   logic                    tag_out_ready;
   logic [CH_W-1:0]         tag_out_chan;
   logic [TAG_W-1:0]        tag_out_data;
   logic [NUM_CH*CNT_W-1:0] chan_occ;
   logic [DROP_W-1:0]       drop_cnt;
   logic                    drop_clr;

   int checks = 0;
   int errors = 0;

   // reference model state
   logic [TAG_W-1:0] mq [NUM_CH][$];
   logic             m_vld;
   logic [CH_W-1:0]  m_chan;
   logic [TAG_W-1:0] m_data;
   int               m_rr;
   logic             m_drop;
   int               m_cnt;

   tmu_tag_mgr #(
      .NUM_CH(NUM_CH), .DEPTH(DEPTH), .TAG_W(TAG_W), .DROP_W(DROP_W)
   ) dut (
      .clk(clk), .rst(rst),
      .tag_in_valid(tag_in_valid), .tag_in_chan(tag_in_chan), .tag_in_data(tag_in_data),
      .tag_in_drop(tag_in_drop),
      .chan_enable(chan_enable), .chan_flush(chan_flush),
      .tag_out_valid(tag_out_valid), .tag_out_ready(tag_out_ready),
      .tag_out_chan(tag_out_chan), .tag_out_data(tag_out_data),
      .chan_occ(chan_occ), .drop_cnt(drop_cnt), .drop_clr(drop_clr)
   );

   always #5 clk = ~clk;

   task automatic model_reset();
      for (int i = 0; i < NUM_CH; i++) mq[i].delete();
      m_vld = 0; m_chan = '0; m_data = '0; m_rr = 0; m_drop = 0; m_cnt = 0;
   endtask

   // One clock of the behaviour, applied to the inputs seen at the edge.
   task automatic model_step();
      int sz[NUM_CH];
      int g;
      int c;
      bit dropped;
      for (int i = 0; i < NUM_CH; i++) sz[i] = mq[i].size();
      g = -1;
      if (!m_vld || tag_out_ready) begin
         for (int k = 0; k < NUM_CH; k++) begin
            c = (m_rr + k) % NUM_CH;
            if (g < 0 && sz[c] > 0 && chan_enable[c] && !chan_flush[c]) g = c;
         end
         if (g >= 0) begin
            m_vld  = 1;
            m_chan = CH_W'(g);
            m_data = mq[g].pop_front();
            m_rr   = (g + 1) % NUM_CH;
         end else begin
            m_vld = 0;
         end
      end
      for (int i = 0; i < NUM_CH; i++) if (chan_flush[i]) mq[i].delete();
      dropped = 0;
      if (tag_in_valid) begin
         c = int'(tag_in_chan);
         if (c >= NUM_CH) dropped = 1;
         else if (chan_flush[c] || sz[c] == DEPTH) dropped = 1;
         else mq[c].push_back(tag_in_data);
      end
      m_drop = dropped;
      if (drop_clr) m_cnt = 0;
      else if (dropped && m_cnt < DMAX) m_cnt++;
   endtask

   function automatic logic [NUM_CH*CNT_W-1:0] exp_occ();
      logic [NUM_CH*CNT_W-1:0] v;
      v = '0;
      for (int i = 0; i < NUM_CH; i++) v[i*CNT_W +: CNT_W] = CNT_W'(mq[i].size());
      return v;
   endfunction

   task automatic tick();
      @(posedge clk);
      if (rst) model_reset();
      else model_step();
      #1;
   endtask

   task automatic set_idle();
      tag_in_valid = 0; tag_in_chan = '0; tag_in_data = '0;
      chan_enable = '1; chan_flush = '0; tag_out_ready = 1; drop_clr = 0;
   endtask

   task automatic do_reset();
      set_idle();
      rst = 1;
      tick();
      tick();
      rst = 0;
   endtask

   task automatic push(input int ch, input logic [TAG_W-1:0] d);
      tag_in_valid = 1; tag_in_chan = CH_W'(ch); tag_in_data = d;
      tick();
      tag_in_valid = 0;
   endtask

   task automatic test_reset();
      set_idle();
      #1 rst = 1;
      #1;
      checks++;
      if (tag_out_valid !== 1'b0 || tag_out_chan !== '0 || tag_out_data !== '0) begin
         errors++; $display("FAIL reset_out got v=%0b c=%0d d=%0h exp 0/0/0", tag_out_valid, tag_out_chan, tag_out_data);
      end
      checks++;
      if (chan_occ !== '0 || drop_cnt !== '0 || tag_in_drop !== 1'b0) begin
         errors++; $display("FAIL reset_cnt got occ=%0h drop_cnt=%0d drop=%0b exp 0", chan_occ, drop_cnt, tag_in_drop);
      end
      tick(); tick();
      rst = 0;
   endtask

   task automatic test_single_tag();
      do_reset();
      push(3, 32'hA5);
      checks++;
      if (chan_occ[3*CNT_W +: CNT_W] !== CNT_W'(1) || tag_out_valid !== 1'b0) begin
         errors++; $display("FAIL single_c0 got occ3=%0d v=%0b exp 1/0", chan_occ[3*CNT_W +: CNT_W], tag_out_valid);
      end
      tick();
      checks++;
      if (tag_out_valid !== 1'b1 || tag_out_chan !== CH_W'(3) || tag_out_data !== 32'hA5) begin
         errors++; $display("FAIL single_c1 got v=%0b c=%0d d=%0h exp 1/3/a5", tag_out_valid, tag_out_chan, tag_out_data);
      end
      checks++;
      if (chan_occ[3*CNT_W +: CNT_W] !== '0) begin
         errors++; $display("FAIL single_occ got %0d exp 0", chan_occ[3*CNT_W +: CNT_W]);
      end
      tick();
      checks++;
      if (tag_out_valid !== 1'b0) begin
         errors++; $display("FAIL single_drain got v=%0b exp 0", tag_out_valid);
      end
   endtask

   task automatic test_fill_drop();
      logic [TAG_W-1:0] sent[17];
      int got;
      do_reset();
      chan_enable = 6'b111110;
      tag_out_ready = 0;
      for (int n = 0; n < 17; n++) begin
         sent[n] = $urandom;
         push(0, sent[n]);
         checks++;
         if (tag_in_drop !== (n == 16)) begin
            errors++; $display("FAIL fill_drop[%0d] got %0b exp %0b", n, tag_in_drop, (n == 16));
         end
      end
      checks++;
      if (chan_occ[0 +: CNT_W] !== CNT_W'(16) || drop_cnt !== DROP_W'(1)) begin
         errors++; $display("FAIL fill_full got occ0=%0d drop_cnt=%0d exp 16/1", chan_occ[0 +: CNT_W], drop_cnt);
      end
      chan_enable = '1;
      tag_out_ready = 1;
      got = 0;
      for (int cyc = 0; cyc < 24 && got < 16; cyc++) begin
         tick();
         if (tag_out_valid) begin
            checks++;
            if (tag_out_data !== sent[got] || tag_out_chan !== '0) begin
               errors++; $display("FAIL drain_order[%0d] got %0h exp %0h", got, tag_out_data, sent[got]);
            end
            got++;
         end
      end
      checks++;
      if (got != 16) begin
         errors++; $display("FAIL drain_count got %0d exp 16", got);
      end
   endtask

   task automatic test_round_robin();
      int exp_ch[6] = '{0, 2, 5, 0, 2, 5};
      do_reset();
      chan_enable = '0;
      for (int r = 0; r < 2; r++) begin
         push(0, 32'h100 + r);
         push(2, 32'h200 + r);
         push(5, 32'h500 + r);
      end
      chan_enable = '1;
      for (int k = 0; k < 6; k++) begin
         tick();
         checks++;
         if (tag_out_valid !== 1'b1 || tag_out_chan !== CH_W'(exp_ch[k])) begin
            errors++; $display("FAIL rr[%0d] got v=%0b c=%0d exp 1/%0d", k, tag_out_valid, tag_out_chan, exp_ch[k]);
         end
      end
   endtask

   task automatic test_backpressure();
      do_reset();
      tag_out_ready = 0;
      push(1, 32'hBEEF);
      tick();
      for (int k = 0; k < 5; k++) begin
         tag_in_valid = 1;
         tag_in_chan = CH_W'($urandom_range(4, 2));
         tag_in_data = $urandom;
         tick();
         checks++;
         if (tag_out_valid !== 1'b1 || tag_out_chan !== CH_W'(1) || tag_out_data !== 32'hBEEF) begin
            errors++; $display("FAIL bp_hold[%0d] got v=%0b c=%0d d=%0h exp 1/1/beef", k, tag_out_valid, tag_out_chan, tag_out_data);
         end
         checks++;
         if (chan_occ !== exp_occ()) begin
            errors++; $display("FAIL bp_occ[%0d] got %0h exp %0h", k, chan_occ, exp_occ());
         end
      end
      tag_in_valid = 0;
      tag_out_ready = 1;
      tick();
      checks++;
      if (tag_out_valid !== m_vld || tag_out_chan !== m_chan || tag_out_data !== m_data) begin
         errors++; $display("FAIL bp_release got c=%0d d=%0h exp %0d/%0h", tag_out_chan, tag_out_data, m_chan, m_data);
      end
   endtask

   task automatic test_enable_flush();
      do_reset();
      chan_enable = 6'b111011;
      for (int n = 0; n < 4; n++) push(2, 32'h2000 + n);
      push(1, 32'h11);
      push(1, 32'h12);
      for (int k = 0; k < 8; k++) begin
         tick();
         checks++;
         if (tag_out_valid === 1'b1 && tag_out_chan === CH_W'(2)) begin
            errors++; $display("FAIL en_skip[%0d] got chan 2 issued exp chan 2 never issued", k);
         end
      end
      checks++;
      if (chan_occ[2*CNT_W +: CNT_W] !== CNT_W'(4)) begin
         errors++; $display("FAIL en_occ got %0d exp 4", chan_occ[2*CNT_W +: CNT_W]);
      end
      chan_flush = 6'b000100;
      push(2, 32'hDEAD);
      chan_flush = '0;
      checks++;
      if (chan_occ[2*CNT_W +: CNT_W] !== '0 || tag_in_drop !== 1'b1 || drop_cnt !== DROP_W'(1)) begin
         errors++; $display("FAIL flush got occ2=%0d drop=%0b cnt=%0d exp 0/1/1", chan_occ[2*CNT_W +: CNT_W], tag_in_drop, drop_cnt);
      end
   endtask

   task automatic test_saturation();
      do_reset();
      for (int n = 0; n < 20; n++) begin
         push(NUM_CH, $urandom);
         checks++;
         if (tag_in_drop !== 1'b1) begin
            errors++; $display("FAIL inv_drop[%0d] got %0b exp 1", n, tag_in_drop);
         end
      end
      checks++;
      if (drop_cnt !== DROP_W'(DMAX)) begin
         errors++; $display("FAIL sat got %0d exp %0d", drop_cnt, DMAX);
      end
      drop_clr = 1;
      push(NUM_CH + 1, 32'h1);
      drop_clr = 0;
      checks++;
      if (drop_cnt !== '0 || tag_in_drop !== 1'b1) begin
         errors++; $display("FAIL clr_prio got cnt=%0d drop=%0b exp 0/1", drop_cnt, tag_in_drop);
      end
   endtask

   task automatic test_random();
      do_reset();
      for (int n = 0; n < 3000; n++) begin
         tag_in_valid  = ($urandom_range(9) < 7);
         tag_in_chan   = CH_W'($urandom_range(7));
         tag_in_data   = $urandom;
         chan_enable   = ($urandom_range(7) == 0) ? NUM_CH'($urandom) : '1;
         chan_flush    = ($urandom_range(19) == 0) ? NUM_CH'(1 << $urandom_range(NUM_CH - 1)) : '0;
         tag_out_ready = ($urandom_range(3) != 0);
         drop_clr      = ($urandom_range(49) == 0);
         tick();
         checks++;
         if (tag_out_valid !== m_vld) begin
            errors++; $display("FAIL rnd_valid[%0d] got %0b exp %0b", n, tag_out_valid, m_vld);
         end
         if (m_vld) begin
            checks++;
            if (tag_out_chan !== m_chan || tag_out_data !== m_data) begin
               errors++; $display("FAIL rnd_out[%0d] got %0d/%0h exp %0d/%0h", n, tag_out_chan, tag_out_data, m_chan, m_data);
            end
         end
         checks++;
         if (tag_in_drop !== m_drop || drop_cnt !== DROP_W'(m_cnt)) begin
            errors++; $display("FAIL rnd_drop[%0d] got %0b/%0d exp %0b/%0d", n, tag_in_drop, drop_cnt, m_drop, m_cnt);
         end
         checks++;
         if (chan_occ !== exp_occ()) begin
            errors++; $display("FAIL rnd_occ[%0d] got %0h exp %0h", n, chan_occ, exp_occ());
         end
      end
      set_idle();
   endtask

   task automatic test_async_reset();
      do_reset();
      tag_out_ready = 0;
      push(1, 32'h77);
      push(4, 32'h88);
      drop_clr = 0;
      push(NUM_CH, 32'h99);
      checks++;
      if (tag_out_valid !== 1'b1 || drop_cnt !== DROP_W'(1)) begin
         errors++; $display("FAIL arst_pre got v=%0b cnt=%0d exp 1/1", tag_out_valid, drop_cnt);
      end
      #1 rst = 1;
      #1;
      checks++;
      if (tag_out_valid !== 1'b0 || tag_out_chan !== '0 || tag_out_data !== '0 ||
          chan_occ !== '0 || drop_cnt !== '0 || tag_in_drop !== 1'b0) begin
         errors++; $display("FAIL arst got v=%0b c=%0d d=%0h occ=%0h cnt=%0d drop=%0b exp all 0",
                            tag_out_valid, tag_out_chan, tag_out_data, chan_occ, drop_cnt, tag_in_drop);
      end
      tick();
      rst = 0;
      set_idle();
   endtask

   initial begin
      model_reset();
      test_reset();
      test_single_tag();
      test_fill_drop();
      test_round_robin();
      test_backpressure();
      test_enable_flush();
      test_saturation();
      test_random();
      test_async_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
